dec_scan_seq: RTL
=================

# dec_scan_seq

Scan sequencer that sits directly upstream of the 3-to-8 decoder. It steps a 3-bit slot index through the enabled slots of an 8-bit mask, holding each slot for a programmable dwell time. It drives the decoder's enable and select inputs, so exactly one decoder output is active per slot. Typical use is time-multiplexed driving of digit or row lines.

## Interface
Parameters:
- DWELL_W, default 8: width of the dwell-count input and the internal dwell counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins scanning when idle.
- stop  in  1  level/pulse; aborts scanning.
- single  in  1  1 = one frame then idle; 0 = continuous; sampled on accepted start.
- mask  in  8  slot-enable mask, bit k = slot k; sampled on accepted start.
- dwell  in  DWELL_W  cycles per slot; sampled on accepted start; 0 treated as 1.
- en  out  1  decoder enable, registered.
- in0, in1, in2  out  1 each  decoder select (slot index bits 0,1,2), registered.
- busy  out  1  high while not in IDLE.
- frame_done  out  1  one-cycle pulse at end of each completed frame.

## Operation
- States: IDLE, SCAN, and BLANK (BLANK exists only with SCAN_BLANK_EN).
- Reset values:
  - State is IDLE.
  - en, in0, in1, in2, busy and frame_done are all 0.
  - Internal dwell counter, mask register and mode register are 0.
- IDLE:
  - start=1, stop=0 and mask≠0: capture mask, dwell (0→1) and single, then go to SCAN.
  - Slot index is the lowest set mask bit.
  - start with mask=0 is ignored.
- SCAN:
  - en=1 and {in2,in1,in0}=current slot.
  - The dwell counter counts captured-dwell cycles.
  - On the last dwell cycle, the next slot is the next higher set bit of the captured mask.
  - If no higher set bit exists, the frame is complete.
- Frame complete:
  - single=1: go to IDLE.
  - single=0: wrap to the lowest set bit.
- Slots with mask bit 0 consume zero cycles.
- BLANK (compiled in only): one cycle with en=0 between consecutive slots, index held at the outgoing slot.
- stop=1 in any state: next cycle is IDLE with en=0, index 0, busy=0 and no frame_done. stop has priority over start in the same cycle.
- start while busy is ignored. mask and dwell changes while busy are ignored until the next accepted start.

## Timing
- Start latency: start accepted at edge N → en=1, busy=1 with the first slot visible after edge N+1.
- Each slot keeps en=1 for exactly dwell_q cycles, where dwell_q is the captured dwell with 0 mapped to 1.
- frame_done:
  - Asserted for one cycle in the cycle after the last dwell cycle of the highest enabled slot.
  - That cycle is the BLANK cycle, the first cycle of the next frame, or the first IDLE cycle.
- Single mode: busy and en fall in the same cycle frame_done is high.
- Frame length, no blank: popcount(mask)·dwell_q cycles.
- Frame length, with blank: popcount(mask)·(dwell_q+1) cycles. A BLANK cycle also follows the final slot in both continuous and single mode.
- The dwell counter is DWELL_W bits wide. dwell = 2^DWELL_W−1 must work without overflow.
- Reset asserted mid-frame takes effect at the next edge. All outputs are at reset values the following cycle.

## Configuration
- SCAN_BLANK_EN defined:
  - The BLANK state is present.
  - One en=0 cycle is inserted after every slot, including the last slot before wrap or idle.
- SCAN_BLANK_EN undefined:
  - No BLANK state.
  - Slots are back-to-back, so en stays continuously 1 while busy.

## Test plan
- Reset: hold rst for 2 cycles with start=1 → en, in0, in1, in2, busy and frame_done all 0, and start is not accepted.
- Full single frame, no blank: mask=8'hFF, dwell=2, single=1 → en=1 for 16 cycles, index 0,0,1,1,…,7,7; then frame_done=1 for one cycle with busy=0 and en=0.
- Sparse continuous: mask=8'h05, dwell=0, single=0 → index sequence 0,2,0,2,… one cycle each; frame_done high every 2nd cycle, coincident with slot 0 from the second frame on.
- Abort and ignore:
  - stop asserted during slot 3 of mask=8'hFF, dwell=4 → next cycle busy=0, en=0, index 0, and frame_done is never pulsed.
  - start with mask=8'h00 → remains IDLE.
  - start and stop together → remains IDLE.
- Blank, with SCAN_BLANK_EN: mask=8'h03, dwell=1, single=1 → en pattern 1,0,1,0 with index 0,0,1,1; frame_done on the 4th cycle; busy=0 from the 5th cycle.
- Max dwell: DWELL_W=4, dwell=15, mask=8'h80 → slot 7 held for exactly 15 cycles.

Source files
------------

// File: rtl/dec_scan_seq.sv
// Scan sequencer feeding a 3-to-8 decoder: steps through the enabled mask slots with a per-slot dwell.
// Optional SCAN_BLANK_EN inserts one en=0 cycle after every slot.
module dec_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic               in0,
    output logic               in1,
    output logic               in2,
    output logic               busy,
    output logic               frame_done
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, BLANK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif

    state_t             state, state_n;
    logic [2:0]         slot, slot_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [7:0]         mask_q, mask_n;
    logic               single_q, single_n;
    logic               fd_q, fd_n;
    logic               en_n, busy_n, fdo_n;
    logic [2:0]         idx_n;
    logic [3:0]         nxt;
    logic               last;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // {found, index} of the next set bit strictly above s
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] s);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (3'(i) > s)) r = {1'b1, 3'(i)};
        return r;
    endfunction

    always_comb begin
        state_n  = state;
        slot_n   = slot;
        cnt_n    = cnt;
        fd_n     = 1'b0;
        mask_n   = mask_q;
        dwell_n  = dwell_q;
        single_n = single_q;
        nxt      = next_above(mask_q, slot);
        last     = (cnt == dwell_q - 1'b1);

        case (state)
            IDLE: begin
                if (start && (mask != 8'h00)) begin
                    state_n  = SCAN;
                    slot_n   = lowest(mask);
                    cnt_n    = '0;
                    mask_n   = mask;
                    dwell_n  = (dwell == '0) ? DWELL_W'(1) : dwell;
                    single_n = single;
                end
            end
            SCAN: begin
                cnt_n = cnt + 1'b1;
                if (last) begin
                    cnt_n = '0;
`ifdef SCAN_BLANK_EN
                    state_n = BLANK;
                    fd_n    = !nxt[3];
`else
                    if (nxt[3]) begin
                        slot_n = nxt[2:0];
                    end else begin
                        fd_n = 1'b1;
                        if (single_q) begin
                            state_n = IDLE;
                            slot_n  = 3'd0;
                        end else begin
                            slot_n = lowest(mask_q);
                        end
                    end
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                // slot still holds the outgoing index, so nxt is the same lookup as in SCAN
                if (nxt[3]) begin
                    state_n = SCAN;
                    slot_n  = nxt[2:0];
                end else if (single_q) begin
                    state_n = IDLE;
                    slot_n  = 3'd0;
                end else begin
                    state_n = SCAN;
                    slot_n  = lowest(mask_q);
                end
            end
`endif
            default: begin
                state_n = IDLE;
                slot_n  = 3'd0;
            end
        endcase

        if (stop) begin
            state_n = IDLE;
            slot_n  = 3'd0;
            cnt_n   = '0;
            fd_n    = 1'b0;
        end

        // outputs lag the state by one register; stop clears them immediately
        en_n   = (state == SCAN) && !stop;
        busy_n = (state != IDLE) && !stop;
        idx_n  = stop ? 3'd0 : slot;
        fdo_n  = fd_q && !stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            slot            <= '0;
            cnt             <= '0;
            dwell_q         <= '0;
            mask_q          <= '0;
            single_q        <= 1'b0;
            fd_q            <= 1'b0;
            en              <= 1'b0;
            {in2, in1, in0} <= 3'd0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            state           <= state_n;
            slot            <= slot_n;
            cnt             <= cnt_n;
            dwell_q         <= dwell_n;
            mask_q          <= mask_n;
            single_q        <= single_n;
            fd_q            <= fd_n;
            en              <= en_n;
            {in2, in1, in0} <= idx_n;
            busy            <= busy_n;
            frame_done      <= fdo_n;
        end
    end

endmodule
